// File: rtl/hex_pkg.sv
//------------------------------------------------------------------------------
// Module   : hex_pkg
// Brief    : Shared constants, FSM state encoding and the nibble-to-ASCII helper
//            for the Intel HEX record emitter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package hex_pkg;

    // Intel HEX record types
    localparam logic [7:0] REC_DATA    = 8'h00;
    localparam logic [7:0] REC_EOF     = 8'h01;

    // ASCII framing characters
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_COLON = 4'd1,
        S_LEN   = 4'd2,
        S_ADDR  = 4'd3,
        S_TYPE  = 4'd4,
        S_FETCH = 4'd5,
        S_WAIT  = 4'd6,
        S_DATA  = 4'd7,
        S_CSUM  = 4'd8,
        S_EOL   = 4'd9,
        S_EOF   = 4'd10,
        S_DONE  = 4'd11
    } state_t;

    // 0-9 -> '0'-'9', 10-15 -> 'A'-'F' (upper case)
    function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return {4'h3, nib};
        end else begin
            return 8'h37 + {4'h0, nib};
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/hex_record_emitter_if.sv
//------------------------------------------------------------------------------
// Module   : hex_record_emitter_if
// Brief    : ROM byte-read port plus the outbound character stream
//            (valid/ready) of the HEX record emitter.
//            master = emitter side, slave = ROM / byte sink side.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface hex_record_emitter_if #(
    parameter int ADDR_W = 15
);
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [7:0]        rd_data;
    logic              out_valid;
    logic [7:0]        out_data;
    logic              out_ready;

    modport master (
        output rd_addr, rd_en, out_valid, out_data,
        input  rd_data, out_ready
    );

    modport slave (
        input  rd_addr, rd_en, out_valid, out_data,
        output rd_data, out_ready
    );
endinterface

`default_nettype wire

// File: rtl/hex_nibble_tx.sv
//------------------------------------------------------------------------------
// Module   : hex_nibble_tx
// Brief    : Sends one loaded value over a valid/ready character stream,
//            either as two upper-case hex digits (high nibble first) or,
//            with single=1, as one raw character. done pulses one cycle
//            after the last character of the item is accepted.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hex_nibble_tx (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       load,
    input  logic       single,
    input  logic [7:0] value,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       done
);
    import hex_pkg::*;

    logic       r_valid;
    logic [7:0] r_data;
    logic [3:0] r_lo;
    logic       r_second;
    logic       r_done;

    // Character register: held stable until accepted, next character the cycle after
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_valid  <= 1'b0;
            r_data   <= 8'h00;
            r_lo     <= 4'h0;
            r_second <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (load) begin
                r_valid  <= 1'b1;
                r_data   <= single ? value : nib2ascii(value[7:4]);
                r_lo     <= value[3:0];
                r_second <= ~single;
            end else if (r_valid && out_ready) begin
                if (r_second) begin
                    r_data   <= nib2ascii(r_lo);
                    r_second <= 1'b0;
                end else begin
                    r_valid <= 1'b0;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign done      = r_done;

endmodule

`default_nettype wire

// File: rtl/hex_record_emitter.sv
//------------------------------------------------------------------------------
// Module   : hex_record_emitter
// Brief    : Reads a ROM byte range and streams it out as an ASCII Intel HEX
//            image: type-00 data records followed by one EOF record.
//            Build option HEX_CRLF_EN: records end in CR LF (default LF only).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hex_record_emitter #(
    parameter int BYTES_PER_REC = 16,
    parameter int ADDR_W        = 15
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     length,
    output logic                busy,
    output logic                done,
    hex_record_emitter_if.master bus
);
    import hex_pkg::*;

    localparam logic [ADDR_W:0] C_SPAN     = (ADDR_W+1)'(1) << ADDR_W;
    localparam logic [ADDR_W:0] C_BPR      = (ADDR_W+1)'(BYTES_PER_REC);
`ifdef HEX_CRLF_EN
    localparam logic [2:0]      C_EOL_LAST = 3'd1;
    localparam logic [2:0]      C_EOF_LAST = 3'd7;
`else
    localparam logic [2:0]      C_EOL_LAST = 3'd0;
    localparam logic [2:0]      C_EOF_LAST = 3'd6;
`endif

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_remaining;
    logic [7:0]        r_reclen;
    logic [7:0]        r_cnt;
    logic [7:0]        r_sum;
    logic [7:0]        r_byte;
    logic [2:0]        r_idx;
    logic              r_loaded;

    logic [ADDR_W:0]   w_room;
    logic [ADDR_W:0]   w_clamp_len;
    logic [7:0]        w_reclen;
    logic [15:0]       w_addr16;
    logic              w_emit;
    logic              w_load;
    logic              w_single;
    logic              w_last;
    logic [7:0]        w_val;
    logic              w_tx_done;

    // Bytes left before the top of the ROM; "base+length > span" is the same
    // as "length > room" and cannot overflow for any length input.
    assign w_room      = C_SPAN - {1'b0, base_addr};
    assign w_clamp_len = (length > w_room) ? w_room : length;
    assign w_reclen    = (r_remaining < C_BPR) ? r_remaining[7:0] : 8'(BYTES_PER_REC);
    assign w_addr16    = 16'(r_addr);

    // State register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and the item each emitting state hands to the character sender
    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b1;
        w_single    = 1'b0;
        w_last      = 1'b1;
        w_val       = 8'h00;
        case (r_state)
            S_IDLE: begin
                w_emit = 1'b0;
                if (start) begin
                    w_state_nxt = (w_clamp_len == '0) ? S_EOF : S_COLON;
                end
            end
            S_COLON: begin
                w_val    = ASCII_COLON;
                w_single = 1'b1;
            end
            S_LEN:  w_val = r_reclen;
            S_ADDR: begin
                w_val  = r_idx[0] ? w_addr16[7:0] : w_addr16[15:8];
                w_last = (r_idx == 3'd1);
            end
            S_TYPE: w_val = REC_DATA;
            S_FETCH: begin
                w_emit      = 1'b0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_emit      = 1'b0;
                w_state_nxt = S_DATA;
            end
            S_DATA: w_val = r_byte;
            S_CSUM: w_val = 8'(~r_sum + 8'd1);
            S_EOL: begin
                w_single = 1'b1;
                w_last   = (r_idx == C_EOL_LAST);
`ifdef HEX_CRLF_EN
                w_val    = (r_idx == 3'd0) ? ASCII_CR : ASCII_LF;
`else
                w_val    = ASCII_LF;
`endif
            end
            S_EOF: begin
                w_last = (r_idx == C_EOF_LAST);
                case (r_idx)
                    3'd0: begin
                        w_val    = ASCII_COLON;
                        w_single = 1'b1;
                    end
                    3'd4:    w_val = REC_EOF;
                    3'd5:    w_val = 8'hFF;
`ifdef HEX_CRLF_EN
                    3'd6: begin
                        w_val    = ASCII_CR;
                        w_single = 1'b1;
                    end
                    3'd7: begin
                        w_val    = ASCII_LF;
                        w_single = 1'b1;
                    end
`else
                    3'd6: begin
                        w_val    = ASCII_LF;
                        w_single = 1'b1;
                    end
`endif
                    default: w_val = 8'h00;
                endcase
            end
            S_DONE: begin
                w_emit      = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_emit      = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_emit && w_tx_done && w_last) begin
            case (r_state)
                S_COLON: w_state_nxt = S_LEN;
                S_LEN:   w_state_nxt = S_ADDR;
                S_ADDR:  w_state_nxt = S_TYPE;
                S_TYPE:  w_state_nxt = S_FETCH;
                S_DATA:  w_state_nxt = (r_cnt == 8'd1) ? S_CSUM : S_FETCH;
                S_CSUM:  w_state_nxt = S_EOL;
                S_EOL:   w_state_nxt = (r_remaining != '0) ? S_COLON : S_EOF;
                S_EOF:   w_state_nxt = S_DONE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Each emitting item is loaded once; r_loaded blocks a reload until done
    assign w_load = w_emit && !r_loaded;

    // Record datapath: address, counters, checksum, fetched byte, item index
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_reclen    <= 8'h00;
            r_cnt       <= 8'h00;
            r_sum       <= 8'h00;
            r_byte      <= 8'h00;
            r_idx       <= 3'd0;
            r_loaded    <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_addr      <= base_addr;
                r_remaining <= w_clamp_len;
            end
            if (w_load) begin
                r_loaded <= 1'b1;
                if (r_state == S_COLON) begin
                    r_reclen <= w_reclen;
                    r_cnt    <= w_reclen;
                    r_sum    <= 8'h00;
                end else if (r_state == S_LEN || r_state == S_ADDR ||
                             r_state == S_TYPE || r_state == S_DATA) begin
                    r_sum <= r_sum + w_val;
                end
            end
            if (w_emit && w_tx_done) begin
                r_loaded <= 1'b0;
                r_idx    <= w_last ? 3'd0 : r_idx + 3'd1;
                if (r_state == S_DATA) begin
                    r_addr      <= r_addr + 1'b1;
                    r_remaining <= r_remaining - 1'b1;
                    r_cnt       <= r_cnt - 8'd1;
                end
            end
            if (r_state == S_WAIT) begin
                r_byte <= bus.rd_data;
            end
        end
    end

    hex_nibble_tx u_tx (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .load      (w_load),
        .single    (w_single),
        .value     (w_val),
        .out_ready (bus.out_ready),
        .out_valid (bus.out_valid),
        .out_data  (bus.out_data),
        .done      (w_tx_done)
    );

    assign bus.rd_addr = r_addr;
    assign bus.rd_en   = (r_state == S_FETCH);
    assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done        = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_hex_record_emitter.sv
//------------------------------------------------------------------------------
// Module   : tb_hex_record_emitter
// Brief    : Scoreboard bench for hex_record_emitter. Expected characters are
//            generated from a ROM model when a job is started and popped as
//            the sink accepts characters.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hex_record_emitter;

    localparam int BPR    = 16;
    localparam int ADDR_W = 15;
    localparam int SPAN   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic              busy;
    logic              done;

    hex_record_emitter_if #(.ADDR_W(ADDR_W)) bus ();

    hex_record_emitter #(
        .BYTES_PER_REC (BPR),
        .ADDR_W        (ADDR_W)
    ) dut (
        .clk_sys   (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [0:SPAN-1];
    logic [7:0] sb [$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_done;
    int         n_rd;
    int         n_acc;
    int         exp_rd;
    bit         rnd_mode = 1'b0;
    bit         hold_pend = 1'b0;
    logic [7:0] hold_data;
    logic [7:0] m_sum;
    string      hx = "0123456789ABCDEF";

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ROM read port model: data valid the cycle after rd_en
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= rom[bus.rd_addr];
    end

    // Sink readiness: always ready, or about 30% duty when rnd_mode is set
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 bus.out_ready = rnd_mode ? ($urandom_range(99, 0) < 30) : 1'b1;
        end
    end

    // Monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!reset_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", bus.out_data, hold_data);
            end
            if (bus.out_valid && bus.out_ready) begin
                n_acc++;
                if (sb.size() == 0) chk("char_unexpected", sb.size(), 1);
                else chk("char", bus.out_data, sb.pop_front());
            end
            if (bus.rd_en) begin
                n_rd++;
                chk("rd_addr", bus.rd_addr, exp_rd);
                exp_rd++;
                chk("rd_while_char", bus.out_valid, 0);
            end
            if (done) n_done++;
            hold_pend = bus.out_valid && !bus.out_ready;
            hold_data = bus.out_data;
        end
    end

    task automatic push_byte(input logic [7:0] b);
        sb.push_back(8'(hx[b[7:4]]));
        sb.push_back(8'(hx[b[3:0]]));
        m_sum = m_sum + b;
    endtask

    task automatic push_eol();
`ifdef HEX_CRLF_EN
        sb.push_back(8'h0D);
`endif
        sb.push_back(8'h0A);
    endtask

    // Builds the expected image; returns the clamped length
    task automatic build_image(input int b, input int l, output int cl);
        int addr;
        int rem;
        int n;
        logic [7:0] cs;
        cl   = (b + l > SPAN) ? SPAN - b : l;
        addr = b;
        rem  = cl;
        while (rem > 0) begin
            n = (rem < BPR) ? rem : BPR;
            m_sum = 8'h00;
            sb.push_back(8'h3A);
            push_byte(8'(n));
            push_byte(8'(addr >> 8));
            push_byte(8'(addr));
            push_byte(8'h00);
            for (int k = 0; k < n; k++) begin
                push_byte(rom[addr]);
                addr++;
                rem--;
            end
            cs = 8'(-m_sum);
            push_byte(cs);
            push_eol();
        end
        sb.push_back(8'h3A);
        push_byte(8'h00);
        push_byte(8'h00);
        push_byte(8'h00);
        push_byte(8'h01);
        push_byte(8'hFF);
        push_eol();
    endtask

    task automatic pulse_start(input int b, input int l);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = ADDR_W'(b);
        length    = (ADDR_W+1)'(l);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_case(input int b, input int l, input bit rnd, input bit poke);
        int cl;
        int cyc;
        sb.delete();
        build_image(b, l, cl);
        exp_rd   = b;
        n_done   = 0;
        n_rd     = 0;
        n_acc    = 0;
        rnd_mode = rnd;
        pulse_start(b, l);
        chk("busy_after_start", busy, 1);
        if (poke) begin
            repeat (5) @(posedge clk);
            pulse_start(0, 1);
        end
        cyc = 0;
        while (n_done == 0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", (n_done != 0), 1);
        repeat (3) @(negedge clk);
        chk("done_pulses", n_done, 1);
        chk("sb_empty", sb.size(), 0);
        chk("rd_count", n_rd, cl);
        chk("busy_idle", busy, 0);
        rnd_mode = 1'b0;
    endtask

    task automatic check_reset_values();
        chk("rst_rd_addr", bus.rd_addr, 0);
        chk("rst_rd_en", bus.rd_en, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
    endtask

    initial begin
        int cyc;
        int cl;
        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        bus.rd_data = 8'h00;
        for (int i = 0; i < SPAN; i++) rom[i] = 8'(i * 37 + 5);
        rom[0] = 8'h0C;
        rom[1] = 8'h94;
        for (int k = 0; k < 17; k++) rom[16'h0100 + k] = 8'(k);

        repeat (3) @(posedge clk);
        #2 check_reset_values();
        #3 reset_n = 1'b1;

        // Two-byte record
        run_case(0, 2, 1'b0, 1'b0);
        // Empty job: EOF record only, no ROM reads
        run_case(0, 0, 1'b0, 1'b0);
        // Full record plus one-byte record; a second start mid-job is ignored
        run_case(16'h0100, 17, 1'b0, 1'b1);
        // Clamped at the top of the ROM
        run_case(16'h7FF8, 32, 1'b0, 1'b0);
        // Same two-byte job under random backpressure
        run_case(0, 2, 1'b1, 1'b0);

        // Reset while a data byte is being sent
        sb.delete();
        build_image(16'h0100, 17, cl);
        exp_rd = 16'h0100;
        n_acc  = 0;
        pulse_start(16'h0100, 17);
        cyc = 0;
        while (n_acc < 10 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_data", (n_acc >= 10), 1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_values();
        sb.delete();
        #10 reset_n = 1'b1;
        run_case(0, 2, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
